hamming_switch_conditioner: RTL and testbench

- Upstream stage of the Hamming check/display top.
- Takes the raw board switches: 4-bit data word `i` concatenated with the 7-bit received Hamming word `e`.
- Synchronizes and debounces the switches, then presents one stable 11-bit word to the decoder.
- Signals each newly settled word with a valid/ack handshake and reports words lost before acknowledgement.

---
 rtl/hamming_switch_conditioner_if.sv | 30 +++
 rtl/hamming_switch_conditioner.sv | 149 ++++++++++++++
 tb/tb_hamming_switch_conditioner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hamming_switch_conditioner_if.sv
// Switch-conditioner bus: raw switch levels and ack flow in, and the
// debounced word, its valid flag, the overrun flag and busy flow out.
interface hamming_switch_conditioner_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic             word_valid;
  logic             word_ack;
  logic             overrun;
  logic             busy;

  modport master (
    input  sw_raw,
    input  word_ack,
    output sw_stable,
    output word_valid,
    output overrun,
    output busy
  );

  modport slave (
    output sw_raw,
    output word_ack,
    input  sw_stable,
    input  word_valid,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/hamming_switch_conditioner.sv
// Switch conditioner ahead of the Hamming check/display path.
// Synchronizes the {i, e} switch bank, waits for it to hold one value for a
// full stability window, then publishes that word with a valid/ack handshake.
module hamming_switch_conditioner #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 270000,
  parameter int CNT_W       = $clog2(CNT_MAX)
) (
  input  logic                         clk,
  input  logic                         rst,
  hamming_switch_conditioner_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COMMIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] candidate_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic [WIDTH-1:0] stable_q;
  logic             valid_q;
  logic             overrun_q;
  logic             busy_q;
  logic             commit;
  logic             ack_take;

  assign sync     = sync_ff[SYNC_STAGES-1];
  assign commit   = (state == COMMIT);
  assign ack_take = bus.word_ack && valid_q;

  // Per-bit synchronizer chain; bits may settle on different cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_ff[k] <= '0;
      end
    end else begin
      sync_ff[0] <= bus.sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_ff[k] <= sync_ff[k-1];
      end
    end
  end

  // Register the synchronized word so FSM decisions start from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync;
    end
  end

  // FSM state, candidate word and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      candidate <= '0;
      counter   <= '0;
    end else begin
      state     <= state_next;
      candidate <= candidate_next;
      counter   <= counter_next;
    end
  end

  // Next-state logic: time a candidate, restart on change, drop on glitch.
  always_comb begin
    state_next     = state;
    candidate_next = candidate;
    counter_next   = counter;
    case (state)
      IDLE: begin
        if (sync_q != stable_q) begin
          candidate_next = sync_q;
          counter_next   = '0;
          state_next     = COUNT;
        end
      end
      COUNT: begin
        if (sync_q == stable_q) begin
          counter_next = '0;
          state_next   = IDLE;
        end else if (sync_q != candidate) begin
          candidate_next = sync_q;
          counter_next   = '0;
        end else if (counter == CNT_LAST) begin
          state_next = COMMIT;
        end else begin
          counter_next = counter + CNT_W'(1);
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Published word, handshake and overrun; an ack in the commit cycle
  // retires the old word so the new one is not counted as lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (commit) begin
      stable_q <= candidate;
      valid_q  <= 1'b1;
      if (valid_q && !bus.word_ack) begin
        overrun_q <= 1'b1;
      end else if (ack_take) begin
        overrun_q <= 1'b0;
      end
    end else if (ack_take) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  // Busy tracks whether the FSM is timing or committing a candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
    end
  end

  assign bus.sw_stable  = stable_q;
  assign bus.word_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_hamming_switch_conditioner.sv
// Self-checking bench for hamming_switch_conditioner with a short window.
module tb_hamming_switch_conditioner;

  localparam int WIDTH       = 11;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = 8;
  localparam int LAT         = SYNC_STAGES + CNT_MAX + 2;

  typedef struct {
    logic [WIDTH-1:0] raw;
    int               hold;
    bit               commit;
    bit               chk;
    logic [WIDTH-1:0] exp_stable;
    bit               exp_valid;
    bit               exp_busy;
    bit               exp_overrun;
  } row_t;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  row_t             rows [15];
  exp_t             sb_q [$];
  exp_t             mon_e;
  int               cyc = 0;
  int               n_total = 0;
  int               n_pass = 0;
  int               t0;
  logic [WIDTH-1:0] prev_stable = '0;

  hamming_switch_conditioner_if #(.WIDTH(WIDTH)) bus ();

  hamming_switch_conditioner #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_MAX    (CNT_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] stable, input bit valid,
                           input bit busy, input bit overrun);
    check_output({tag, "_stable"}, 32'(bus.sw_stable), 32'(stable));
    check_output({tag, "_valid"}, 32'(bus.word_valid), 32'(valid));
    check_output({tag, "_busy"}, 32'(bus.busy), 32'(busy));
    check_output({tag, "_overrun"}, 32'(bus.overrun), 32'(overrun));
  endtask

  // Called at a negedge; drives one raw value for hold cycles, returns at a negedge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] raw, input int hold, input bit commit);
    bus.sw_raw = raw;
    if (commit) sb_q.push_back('{word: raw, due: cyc + 1 + LAT});
    repeat (hold) @(negedge clk);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply_stimulus(rows[i].raw, rows[i].hold, rows[i].commit);
      if (rows[i].chk)
        check_all($sformatf("row%0d", i), rows[i].exp_stable, rows[i].exp_valid,
                  rows[i].exp_busy, rows[i].exp_overrun);
    end
  endtask

  task automatic pulse_ack();
    bus.word_ack = 1'b1;
    @(negedge clk);
    bus.word_ack = 1'b0;
  endtask

  // Commit monitor: every change of sw_stable must match the next expected word and cycle.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stable = '0;
    end else if (bus.sw_stable !== prev_stable) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_commit", 32'(bus.sw_stable), 32'(prev_stable));
      end else begin
        mon_e = sb_q.pop_front();
        check_output("commit_word", 32'(bus.sw_stable), 32'(mon_e.word));
        check_output("commit_cycle", 32'(cyc), 32'(mon_e.due));
      end
      prev_stable = bus.sw_stable;
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rows[0]  = '{raw: 11'h2E7, hold: 5,  commit: 0, chk: 1, exp_stable: 11'h2E6, exp_valid: 0, exp_busy: 1, exp_overrun: 0};
    rows[1]  = '{raw: 11'h2E6, hold: 20, commit: 0, chk: 1, exp_stable: 11'h2E6, exp_valid: 0, exp_busy: 0, exp_overrun: 0};
    for (int i = 2; i <= 11; i++)
      rows[i] = '{raw: (i % 2 == 0) ? 11'h055 : 11'h2E6, hold: 3, commit: 0, chk: 0,
                  exp_stable: '0, exp_valid: 0, exp_busy: 0, exp_overrun: 0};
    rows[12] = '{raw: 11'h055, hold: 25, commit: 1, chk: 1, exp_stable: 11'h055, exp_valid: 1, exp_busy: 0, exp_overrun: 0};
    rows[13] = '{raw: 11'h2E6, hold: 14, commit: 1, chk: 1, exp_stable: 11'h2E6, exp_valid: 1, exp_busy: 0, exp_overrun: 0};
    rows[14] = '{raw: 11'h055, hold: 14, commit: 1, chk: 1, exp_stable: 11'h055, exp_valid: 1, exp_busy: 0, exp_overrun: 1};

    rst          = 1'b1;
    bus.sw_raw   = '0;
    bus.word_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", '0, 0, 0, 0);
    rst = 1'b0;

    // Clean change: exact latency and busy window.
    bus.sw_raw = 11'h2E6;
    t0 = cyc + 1;
    sb_q.push_back('{word: 11'h2E6, due: t0 + LAT});
    for (int n = 0; n <= LAT; n++) begin
      @(negedge clk);
      check_output($sformatf("first_busy_n%0d", n), 32'(bus.busy),
                   32'(n >= SYNC_STAGES + 1 && n < LAT));
      check_output($sformatf("first_valid_n%0d", n), 32'(bus.word_valid), 32'(n >= LAT));
    end
    check_output("first_stable", 32'(bus.sw_stable), 32'(11'h2E6));
    pulse_ack();
    check_all("first_ack", 11'h2E6, 0, 0, 0);

    // Short pulse is filtered, then bounce settles on one commit.
    apply_rows(0, 12);
    pulse_ack();
    check_all("bounce_ack", 11'h055, 0, 0, 0);

    // Two commits with no ack raise overrun; one ack clears both flags.
    apply_rows(13, 14);
    pulse_ack();
    check_all("overrun_ack", 11'h055, 0, 0, 0);

    // Ack while nothing is pending changes nothing.
    pulse_ack();
    check_all("idle_ack", 11'h055, 0, 0, 0);

    // Ack landing on the same edge as the second commit.
    apply_stimulus(11'h2E6, 14, 1);
    bus.sw_raw = 11'h055;
    sb_q.push_back('{word: 11'h055, due: cyc + 1 + LAT});
    repeat (LAT) @(negedge clk);
    bus.word_ack = 1'b1;
    @(negedge clk);
    bus.word_ack = 1'b0;
    check_all("same_edge_ack", 11'h055, 1, 0, 0);
    pulse_ack();
    check_all("same_edge_clear", 11'h055, 0, 0, 0);

    // Reset in the middle of timing a candidate discards it.
    bus.sw_raw = 11'h3FF;
    repeat (SYNC_STAGES + 1 + 4) @(negedge clk);
    check_output("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_all("mid_count_rst", '0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back('{word: 11'h3FF, due: cyc + 1 + LAT});
    for (int n = 0; n < 60 && sb_q.size() > 0; n++) @(negedge clk);
    #2;
    check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check_all("after_rst_commit", 11'h3FF, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
